// File: rtl/zyy_ps2_key_rx.sv
// PS/2 keyboard receiver with frame checking, E0/F0 prefix decoding, an event FIFO
// with a show-ahead valid/ready pop port, and a held-key bitmap for the 8 game keys.
module zyy_ps2_key_rx #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_clk,
    input  logic                          key_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_break,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic [7:0]                    key_state,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    // Synchronisers and falling-edge detect
    logic [SYNC_STAGES-1:0] kc_sync;
    logic [SYNC_STAGES-1:0] kd_sync;
    logic                   kc_prev;
    logic                   kc_s;
    logic                   kd_s;
    logic                   fall;

    // Frame receiver state
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic [TW-1:0] tmr;
    logic          ext_f;
    logic          brk_f;

    // FIFO state
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic [9:0]    head;

    // Combinational decode
    logic       timeout;
    logic       byte_ok;
    logic       bad;
    logic       is_e0;
    logic       is_f0;
    logic       ev_new;
    logic       full;
    logic       push;
    logic       pop;
    logic       khit;
    logic [2:0] kidx;
    logic [7:0] ks_d;

    assign kc_s = kc_sync[SYNC_STAGES-1];
    assign kd_s = kd_sync[SYNC_STAGES-1];
    assign fall = kc_prev & ~kc_s;

    // Bring the PS/2 lines into the clk domain; both lines see the same depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kc_sync <= '1;
            kd_sync <= '1;
            kc_prev <= 1'b1;
        end else begin
            kc_sync <= {kc_sync[SYNC_STAGES-2:0], key_clk};
            kd_sync <= {kd_sync[SYNC_STAGES-2:0], key_data};
            kc_prev <= kc_s;
        end
    end

    // Frame checks, prefix recognition, FIFO handshake and game-key mapping
    always_comb begin
        timeout = !fall && (bit_cnt != 4'd0) && (tmr == TW'(TIMEOUT_CYC - 1));
        // data^parity must hold an odd number of ones
        byte_ok = fall && (bit_cnt == 4'd10) && kd_s && (^{shreg, par_q});
        bad     = (fall && (bit_cnt == 4'd0) && kd_s)
                || (fall && (bit_cnt == 4'd10) && !byte_ok)
                || timeout;
        is_e0   = (shreg == 8'hE0);
        is_f0   = (shreg == 8'hF0);
        ev_new  = byte_ok && !is_e0 && !is_f0;
        full    = (count == CW'(FIFO_DEPTH));
        pop     = ev_valid && ev_ready;
        push    = ev_new && (!full || pop);

        khit = 1'b0;
        kidx = 3'd0;
        if (ext_f) begin
            unique case (shreg)
                8'h75:   begin khit = 1'b1; kidx = 3'd0; end
                8'h72:   begin khit = 1'b1; kidx = 3'd1; end
                8'h6B:   begin khit = 1'b1; kidx = 3'd2; end
                8'h74:   begin khit = 1'b1; kidx = 3'd3; end
                default: ;
            endcase
        end else begin
            unique case (shreg)
                8'h1D:   begin khit = 1'b1; kidx = 3'd4; end
                8'h1B:   begin khit = 1'b1; kidx = 3'd5; end
                8'h1C:   begin khit = 1'b1; kidx = 3'd6; end
                8'h23:   begin khit = 1'b1; kidx = 3'd7; end
                default: ;
            endcase
        end

        ks_d = key_state;
        if (ev_new && khit) begin
            ks_d[kidx] = !brk_f;
        end
    end

    // Bit counter, shift register, inter-bit timer, prefix flags and status pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            par_q     <= 1'b0;
            tmr       <= '0;
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            key_state <= 8'h00;
        end else begin
            if (fall) begin
                tmr <= '0;
                case (bit_cnt)
                    4'd0: begin
                        // a high start bit is rejected and leaves the counter at 0
                        if (!kd_s) begin
                            bit_cnt <= 4'd1;
                        end
                    end
                    4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
                        shreg   <= {kd_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    4'd9: begin
                        par_q   <= kd_s;
                        bit_cnt <= 4'd10;
                    end
                    default: bit_cnt <= 4'd0;
                endcase
            end else if (bit_cnt != 4'd0) begin
                if (timeout) begin
                    bit_cnt <= 4'd0;
                    tmr     <= '0;
                end else begin
                    tmr <= tmr + TW'(1);
                end
            end else begin
                tmr <= '0;
            end

            if (bad) begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end else if (byte_ok) begin
                if (is_e0) begin
                    ext_f <= 1'b1;
                end else if (is_f0) begin
                    brk_f <= 1'b1;
                end else begin
                    ext_f <= 1'b0;
                    brk_f <= 1'b0;
                end
            end

            frame_err <= bad;
            overflow  <= ev_new && full && !pop;
            key_state <= ks_d;
        end
    end

    // Event storage; contents need no reset since outputs are gated by ev_valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {brk_f, ext_f, shreg};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Show-ahead head of queue
    always_comb begin
        ev_valid = (count != '0);
        ev_count = count;
        head     = mem[rptr];
        ev_code  = ev_valid ? head[7:0] : 8'h00;
        ev_ext   = ev_valid ? head[8]   : 1'b0;
        ev_break = ev_valid ? head[9]   : 1'b0;
    end

endmodule
